line_mem_ctrl: RTL and testbench

LINE_MEM_CTRL -- requirements
Module: line_mem_ctrl

---
 rtl/line_mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_line_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem_ctrl
//  Purpose  : Moves one cache line (LINE_WORDS x 32-bit words) between a
//             cache-side request/response port and a single-beat, 32-bit
//             memory port.
//             - Fills (reads) go critical-word-first and wrap within the line.
//             - Writebacks always go in word order 0..3.
//             Each fill beat is stored in its own word slot, so the order in
//             which beats are issued does not affect the returned line.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1    rising-edge clock for all state
//    reset      in   1    synchronous, active-low reset
//    req_valid  in   1    cache presents a line request
//    req_write  in   1    1 = writeback, 0 = fill
//    req_addr   in   32   byte address of the requested word
//    req_wline  in   128  writeback line, word k in bits [32k+31:32k]
//    req_ready  out  1    controller is idle and accepts a request
//    rsp_valid  out  1    fill/writeback complete, response held
//    rsp_rline  out  128  fill line, same word packing as req_wline
//    rsp_ready  in   1    cache consumes the response
//    mem_re     out  1    memory read strobe
//    mem_we     out  1    memory write strobe
//    mem_hsel   out  1    memory select
//    mem_a      out  32   memory byte address (word aligned)
//    mem_wd     out  32   memory write data
//    mem_rd     in   32   memory read data, combinational from mem_a
//    mem_valid  in   1    memory accepts the current beat
// ============================================================================
module line_mem_ctrl #(
    parameter int LINE_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [32*LINE_WORDS-1:0]  req_wline,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output logic [32*LINE_WORDS-1:0]  rsp_rline,
    input  logic                      rsp_ready,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic                      mem_hsel,
    output logic [31:0]               mem_a,
    output logic [31:0]               mem_wd,
    input  logic [31:0]               mem_rd,
    input  logic                      mem_valid
);

    localparam int c_LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [1:0]              cnt_q,   cnt_d;     // completed beats
    logic [27:0]             addr_q,  addr_d;    // line address, req_addr[31:4]
    logic [1:0]              crit_q,  crit_d;    // critical word, req_addr[3:2]
    logic [c_LINE_BITS-1:0]  wline_q, wline_d;   // captured writeback line
    logic [c_LINE_BITS-1:0]  rline_q, rline_d;   // assembled fill line

    // Word slot of the beat currently on the bus. Fills start at the
    // critical word and wrap modulo 4 through the natural 2-bit overflow.
    logic [1:0]              w_beat;

    // Byte-offset bits of the request are irrelevant to a line transfer.
    logic                    w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[1:0]};

    always_comb begin
        w_beat = cnt_q;
        if (state_q == ST_READ) begin
            w_beat = crit_q + cnt_q;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 28'd0;
            crit_q  <= 2'd0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            crit_q  <= crit_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        crit_d    = crit_q;
        wline_d   = wline_q;
        rline_d   = rline_q;

        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_hsel  = 1'b0;
        mem_a     = 32'd0;
        mem_wd    = 32'd0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Capture everything the transfer needs so later changes
                    // on req_* cannot disturb it.
                    addr_d  = req_addr[31:4];
                    crit_d  = req_addr[3:2];
                    wline_d = req_wline;
                    cnt_d   = 2'd0;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end

            ST_READ: begin
                mem_re   = 1'b1;
                mem_hsel = 1'b1;
                mem_a    = {addr_q, w_beat, 2'b00};
                if (mem_valid) begin
                    rline_d[32*w_beat +: 32] = mem_rd;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_WRITE: begin
                mem_we   = 1'b1;
                mem_hsel = 1'b1;
                mem_a    = {addr_q, w_beat, 2'b00};
                mem_wd   = wline_q[32*w_beat +: 32];
                if (mem_valid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // A writeback leaves rline_q untouched, so the response line
                // repeats whatever the last fill (or reset) left there.
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_rline = rline_q;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_mem_ctrl
//  Purpose  : Directed and randomized bench for line_mem_ctrl with a word
//             memory model and a line-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_mem_ctrl;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wline;
    logic         req_ready;
    logic         rsp_valid;
    logic [127:0] rsp_rline;
    logic         rsp_ready;
    logic         mem_re;
    logic         mem_we;
    logic         mem_hsel;
    logic [31:0]  mem_a;
    logic [31:0]  mem_wd;
    logic [31:0]  mem_rd;
    logic         mem_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected response line: last fill result, cleared by reset.
    logic [127:0] exp_line;

    // Memory: 1024 words, indexed by byte address bits [11:2].
    logic [31:0] mem [0:1023];

    line_mem_ctrl #(.LINE_WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wline (req_wline),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rline (rsp_rline),
        .rsp_ready (rsp_ready),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_hsel  (mem_hsel),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .mem_valid (mem_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rd = mem[mem_a[11:2]];

    always @(posedge clk) begin
        if (mem_we && mem_hsel && mem_valid) begin
            mem[mem_a[11:2]] = mem_wd;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input bit wr, input logic [31:0] ea, input logic [31:0] ed);
        chk("beat_mem_a", {96'd0, mem_a}, {96'd0, ea});
        chk("beat_hsel", {127'd0, mem_hsel}, 128'd1);
        chk("beat_re", {127'd0, mem_re}, {127'd0, !wr});
        chk("beat_we", {127'd0, mem_we}, {127'd0, wr});
        if (wr) chk("beat_wd", {96'd0, mem_wd}, {96'd0, ed});
        chk("beat_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("beat_req_ready", {127'd0, req_ready}, 128'd0);
    endtask

    // One full line transfer, checked beat by beat against the line-level
    // rules: fill order starts at the critical word and wraps, writeback
    // order is 0..3, every beat address is line base + 4*slot.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [127:0] wl,
                        input int stall_beat, input int stall_len, input int rand_stall,
                        input int hold, input bit queue_next, input logic [31:0] next_addr);
        logic [31:0]  base;
        logic [9:0]   bidx;
        logic [127:0] fill;
        logic [31:0]  ea;
        int           crit;
        int           slot;
        int           n;
        int           stalls;
        int           start;
        base   = {addr[31:4], 4'h0};
        bidx   = base[11:2];
        crit   = int'(addr[3:2]);
        stalls = 0;
        for (int k = 0; k < 4; k++) fill[32*k +: 32] = mem[bidx + 10'(k)];

        chk("idle_req_ready", {127'd0, req_ready}, 128'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wline = wl;
        mem_valid = 1'($urandom);
        tick();
        start = cyc;
        // Disturb the request inputs; the transfer must ignore them.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wline = {$urandom, $urandom, $urandom, $urandom};

        for (int i = 0; i < 4; i++) begin
            slot = wr ? i : (crit + i) % 4;
            ea   = base + 32'(slot * 4);
            n    = (i == stall_beat) ? stall_len : 0;
            if (rand_stall > 0) n += $urandom_range(0, rand_stall);
            for (int s = 0; s < n; s++) begin
                mem_valid = 1'b0;
                chk_beat(wr, ea, wl[32*slot +: 32]);
                tick();
                stalls++;
            end
            mem_valid = 1'b1;
            chk_beat(wr, ea, wl[32*slot +: 32]);
            tick();
        end
        mem_valid = 1'($urandom);

        if (!wr) exp_line = fill;
        chk("latency", 128'(cyc - start), 128'(4 + stalls));
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            chk("resp_valid_hold", {127'd0, rsp_valid}, 128'd1);
            chk("resp_line_hold", rsp_rline, exp_line);
            chk("resp_req_ready", {127'd0, req_ready}, 128'd0);
            chk("resp_strobes", {125'd0, mem_re, mem_we, mem_hsel}, 128'd0);
            if (queue_next) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = next_addr;
            end
            tick();
        end
        chk("resp_valid", {127'd0, rsp_valid}, 128'd1);
        chk("resp_line", rsp_rline, exp_line);
        chk("resp_mem_a", {96'd0, mem_a}, 128'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("exit_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("exit_req_ready", {127'd0, req_ready}, 128'd1);
        if (wr) begin
            for (int k = 0; k < 4; k++)
                chk("wb_mem", {96'd0, mem[bidx + 10'(k)]}, {96'd0, wl[32*k +: 32]});
        end
    endtask

    initial begin
        logic [31:0]  old2;
        logic [31:0]  old3;
        logic [127:0] wl;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wline = 128'd0;
        rsp_ready = 1'b0;
        mem_valid = 1'b0;
        exp_line  = 128'd0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b1;
        chk("rst_req_ready", {127'd0, req_ready}, 128'd1);
        chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("rst_rline", rsp_rline, 128'd0);
        chk("rst_mem", {mem_re, mem_we, mem_hsel, mem_a, mem_wd}, 128'd0);

        // Aligned fill, no stalls.
        xfer(1'b0, 32'h0000_0100, 128'd0, -1, 0, 0, 0, 1'b0, 32'd0);
        // Critical-word-first fill with wrap.
        xfer(1'b0, 32'h0000_0208, 128'd0, -1, 0, 0, 1, 1'b0, 32'd0);
        // Writeback addressed at the last word still starts at word 0.
        xfer(1'b1, 32'h0000_030C, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
             -1, 0, 0, 0, 1'b0, 32'd0);
        // Three-cycle memory stall on beat 2 of a writeback.
        xfer(1'b1, 32'h0000_0500, {$urandom, $urandom, $urandom, $urandom},
             2, 3, 0, 0, 1'b0, 32'd0);
        // Response held for 4 cycles with a queued request behind it.
        xfer(1'b0, 32'h0000_0604, 128'd0, -1, 0, 0, 4, 1'b1, 32'h0000_0700);
        xfer(1'b0, 32'h0000_0700, 128'd0, -1, 0, 0, 0, 1'b0, 32'd0);

        // Reset during writeback beat 1.
        wl   = {$urandom, $urandom, $urandom, $urandom};
        old2 = mem[10'h102];
        old3 = mem[10'h103];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0400;
        req_wline = wl;
        tick();
        req_valid = 1'b0;
        mem_valid = 1'b1;
        chk("abort_beat0_a", {96'd0, mem_a}, 128'h400);
        tick();
        chk("abort_beat1_a", {96'd0, mem_a}, 128'h404);
        chk("abort_beat1_we", {127'd0, mem_we}, 128'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_line = 128'd0;
        chk("abort_req_ready", {127'd0, req_ready}, 128'd1);
        chk("abort_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("abort_rline", rsp_rline, 128'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_beat", {126'd0, mem_we, mem_hsel}, 128'd0);
            chk("abort_idle_rsp", {127'd0, rsp_valid}, 128'd0);
            tick();
        end
        chk("abort_w0", {96'd0, mem[10'h100]}, {96'd0, wl[31:0]});
        chk("abort_w1", {96'd0, mem[10'h101]}, {96'd0, wl[63:32]});
        chk("abort_w2", {96'd0, mem[10'h102]}, {96'd0, old2});
        chk("abort_w3", {96'd0, mem[10'h103]}, {96'd0, old3});

        // Randomized transfers with random stalls and response holds.
        for (int t = 0; t < 24; t++) begin
            xfer(1'($urandom), $urandom,
                 {$urandom, $urandom, $urandom, $urandom},
                 -1, 0, 2, $urandom_range(0, 2), 1'b0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
